crc_stream_engine: RTL
======================

Name: crc_stream_engine

Overview:
- Parametrised successor to the fixed 8-bit CRC-16 parallel block.
- Computes any CRC up to 32 bits, programmed by polynomial, init, reflection and output-XOR parameters, over a multi-byte-per-beat valid/ready stream with frame delimiters and a partial last beat.
- Holds each frame result in a one-entry output buffer with its own handshake, and flags a good-frame residue check.
- Sits between the packet datapath and the framer/checker.

Parameters:
- CRC_W, 16, CRC register width (8..32).
- POLY, 16'h1021, generator polynomial, implicit top bit, normal (MSB-first) form.
- INIT, 16'hFFFF, seed loaded on every start-of-frame beat.
- XOR_OUT, 16'h0000, XOR applied to the reported CRC.
- REFIN, 0, 1 = reflect each input byte before folding.
- REFOUT, 0, 1 = reflect the final register before XOR_OUT.
- RESIDUE, 16'h0000, register value that marks a good frame with its CRC appended.
- DATA_W, 32, input beat width; must be a multiple of 8 (NB = DATA_W/8).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  beat; byte [DATA_W-1:DATA_W-8] is processed first.
- in_sof  in  1  first beat of frame.
- in_eof  in  1  last beat of frame.
- in_nbytes  in  clog2(NB)+1  valid bytes on the eof beat, left-justified.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_crc  out  CRC_W  final CRC after REFOUT and XOR_OUT.
- out_match  out  1  raw final register == RESIDUE.
- drop_cnt  out  8  saturating count of beats discarded outside a frame.

Behaviour:
- Reset (async, rst=1): state IDLE, crc register = INIT, out_valid=0, out_crc=0, out_match=0, drop_cnt=0. in_ready=1 once reset is released.
- in_ready = !out_valid. A new beat is not accepted while a result is pending.
- States:
  - IDLE, no frame open.
  - ACCUM, frame open.
- Accepted beat with in_sof=1 (any state): fold starts from INIT; the previous frame, if any, is abandoned with no output.
- Accepted beat with in_sof=0 in ACCUM: fold starts from the current register.
- Accepted beat with in_sof=0 in IDLE: beat is discarded, drop_cnt += 1 (saturates at 255), no register change.
- Fold: bytes are processed serially MSB-first within the byte (after optional REFIN), all in one cycle.
  - Non-eof beats use all NB bytes.
  - eof beats use the first in_nbytes bytes; in_nbytes of 0 or >NB is treated as NB.
- State updates:
  - sof without eof → ACCUM.
  - eof (including sof&eof on the same beat) → IDLE.
  - On eof, register the result: out_valid=1 the cycle after the eof beat is accepted (latency 1).
  - out_crc = (REFOUT ? reflect(reg) : reg) ^ XOR_OUT; out_match = (reg == RESIDUE), where reg is the raw register.
- out_crc and out_match stay stable while out_valid & !out_ready.
- out_valid clears on handshake. in_ready rises in that same cycle combinationally, so back-to-back frames are possible.
- After the eof beat, the register is reseeded to INIT.
- Reset mid-frame: the partial frame is lost and the pending output is dropped.

Test Plan:
- Defaults, frame "1234","5678" (nbytes=4), "9" (eof, nbytes=1) → one cycle after eof: out_valid=1, out_crc=16'h29B1, out_match=0.
- Defaults, frame bytes "123456789",8'h29,8'hB1 over 3 beats (last nbytes=3) → out_crc=16'h0000, out_match=1.
- REFIN=1, REFOUT=1, INIT=16'h0000, input "123456789" → out_crc=16'h2189. Then single beat sof&eof "1" (nbytes=1) → a separate result with no carry-over from the previous frame.
- Result pending with out_ready=0 for 3 cycles → in_ready=0 and out_crc held at 16'h29B1 throughout. Next frame's sof beat is accepted only after the handshake.
- Beat with sof=0 while IDLE → drop_cnt=1, no out_valid. Then sof beat "ABCD", a second sof beat "1234" (restart), "5678", then eof "9" → out_crc=16'h29B1.
- rst pulsed after the first beat of a frame → all outputs zero, in_ready=1. A subsequent clean "123456789" frame → 16'h29B1.

Source files
------------

// File: rtl/crc_stream_engine.sv
// crc_stream_engine
//
// Parametrised streaming CRC engine. It folds a multi-byte-per-beat
// valid/ready stream into a CRC register of up to 32 bits. Frames are
// delimited by sof/eof, and the eof beat may be partial. Each finished
// frame's CRC is held in a one-entry output buffer with its own handshake.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   in_valid      input beat valid
//   in_ready      input beat accepted when in_valid & in_ready
//   in_data       input beat; the most significant byte is processed first
//   in_sof        first beat of a frame
//   in_eof        last beat of a frame
//   in_nbytes     number of valid left-justified bytes on the eof beat
//   out_valid     frame result available
//   out_ready     result consumed when out_valid & out_ready
//   out_crc       final CRC after output reflection and XOR
//   out_match     raw final register equals the good-frame residue
//   drop_cnt      saturating count of beats discarded outside a frame

module crc_stream_engine #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000,
    parameter int               DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_sof,
    input  logic                        in_eof,
    input  logic [$clog2(DATA_W/8):0]   in_nbytes,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CRC_W-1:0]            out_crc,
    output logic                        out_match,
    output logic [7:0]                  drop_cnt
);

    localparam int NB = DATA_W / 8;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state, state_next;
    logic [CRC_W-1:0]   crc_reg, crc_next;
    logic [CRC_W-1:0]   folded;
    logic [CRC_W-1:0]   out_crc_next;
    logic               out_valid_next;
    logic               out_match_next;
    logic [7:0]         drop_next;
    logic               accept;
    int                 eff_n;

    function automatic logic [7:0] reflect8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] reflect_crc(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
        return r;
    endfunction

    // Bit-serial MSB-first division unrolled over every byte lane. Lanes at
    // or beyond nuse are skipped, which handles the partial eof beat.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] seed,
                                              input logic [DATA_W-1:0] data,
                                              input int nuse);
        logic [CRC_W-1:0] c;
        logic [7:0]       bt;
        logic             fb;
        c = seed;
        for (int b = 0; b < NB; b++) begin
            bt = data[DATA_W-1-8*b -: 8];
            if (REFIN) bt = reflect8(bt);
            if (b < nuse) begin
                for (int i = 7; i >= 0; i--) begin
                    fb = c[CRC_W-1] ^ bt[i];
                    c  = {c[CRC_W-2:0], 1'b0};
                    if (fb) c = c ^ POLY;
                end
            end
        end
        return c;
    endfunction

    // A pending result blocks new input so that the single-entry buffer is
    // never overwritten.
    assign in_ready = !out_valid;
    assign accept   = in_valid && in_ready;

    // An out-of-range byte count on the eof beat means a full beat.
    always_comb begin
        eff_n = NB;
        if (in_eof && (in_nbytes != '0) && (int'(in_nbytes) <= NB))
            eff_n = int'(in_nbytes);
    end

    // A sof beat always reseeds, which also abandons any open frame.
    assign folded = fold(in_sof ? INIT : crc_reg, in_data, eff_n);

    // Next-state and datapath decisions for one accepted beat.
    always_comb begin
        state_next     = state;
        crc_next       = crc_reg;
        out_valid_next = out_valid && !out_ready;
        out_crc_next   = out_crc;
        out_match_next = out_match;
        drop_next      = drop_cnt;
        if (accept) begin
            if (in_sof || (state == ACCUM)) begin
                if (in_eof) begin
                    state_next     = IDLE;
                    crc_next       = INIT;
                    out_valid_next = 1'b1;
                    out_crc_next   = (REFOUT ? reflect_crc(folded) : folded) ^ XOR_OUT;
                    out_match_next = (folded == RESIDUE);
                end else begin
                    state_next = ACCUM;
                    crc_next   = folded;
                end
            end else if (drop_cnt != 8'hFF) begin
                drop_next = drop_cnt + 8'd1;
            end
        end
    end

    // State, CRC register and output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            out_valid <= 1'b0;
            out_crc   <= '0;
            out_match <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_next;
            crc_reg   <= crc_next;
            out_valid <= out_valid_next;
            out_crc   <= out_crc_next;
            out_match <= out_match_next;
            drop_cnt  <= drop_next;
        end
    end

endmodule
